fill_ones_d: RTL and testbench



---
 rtl/fill_ones_d.sv | 129 ++++++++++++
 tb/tb_fill_ones_d.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fill_ones_d.sv
// fill_ones_d: serially builds a data_width-bit thermometer word holding a
// requested number of ones at the LSB end, one bit per clock, with a
// start/busy/done handshake. Counts above data_width are clamped and flagged.
module fill_ones_d #(
  parameter int unsigned data_width  = 4,
  parameter int unsigned count_width = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [count_width-1:0] bit_count,
  output logic [data_width-1:0]  data,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   sat
);

  localparam int unsigned IDX_W = (data_width > 1) ? $clog2(data_width) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [count_width-1:0] rem_q, rem_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [data_width-1:0]  data_d;
  logic                   bit_out_d, bit_valid_d, busy_d, done_d, sat_d;

  logic                   over_c;
  logic [count_width-1:0] clamp_c;
  logic                   shift_bit_c;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    data_d      = data;
    bit_out_d   = bit_out;
    bit_valid_d = bit_valid;
    busy_d      = busy;
    done_d      = done;
    sat_d       = sat;

    over_c      = 32'(bit_count) > data_width;
    clamp_c     = over_c ? count_width'(data_width) : bit_count;
    shift_bit_c = (rem_q != '0);

    unique case (state_q)
      IDLE: begin
        done_d      = 1'b0;
        bit_valid_d = 1'b0;
        bit_out_d   = 1'b0;
        if (start) begin
          rem_d   = clamp_c;
          sat_d   = over_c;
          data_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // New bit enters at the MSB so the ones settle at the LSB end.
        data_d      = {shift_bit_c, data[data_width-1:1]};
        bit_out_d   = shift_bit_c;
        bit_valid_d = 1'b1;
        rem_d       = rem_q - count_width'(shift_bit_c);
        idx_d       = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(data_width - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        done_d      = 1'b0;
        bit_valid_d = 1'b0;
        bit_out_d   = 1'b0;
        if (start) begin
          // Back-to-back accept: no idle cycle between words.
          rem_d   = clamp_c;
          sat_d   = over_c;
          data_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      idx_q     <= '0;
      data      <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      data      <= data_d;
      bit_out   <= bit_out_d;
      bit_valid <= bit_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      sat       <= sat_d;
    end
  end

endmodule

// File: tb/tb_fill_ones_d.sv
// Directed testbench for fill_ones_d (data_width=4, count_width=3).
module tb_fill_ones_d;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] bit_count;
  logic [3:0] data;
  logic       bit_out;
  logic       bit_valid;
  logic       busy;
  logic       done;
  logic       sat;

  int checks = 0;
  int errors = 0;

  fill_ones_d #(
    .data_width (4),
    .count_width(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bit_count(bit_count),
    .data     (data),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .busy     (busy),
    .done     (done),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then sampled and inputs driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full word from an idle/done state. prog holds the data value after
  // shift i in nibble i-1 (hand-computed); n is the clamped ones count.
  task automatic run_word(input string tag, input logic [2:0] cnt, input int n,
                          input logic [15:0] prog, input logic exp_sat);
    logic [3:0] nib;
    start     = 1'b1;
    bit_count = cnt;
    tick();
    start     = 1'b0;
    chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
    chk({tag, "_acc_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_acc_data"}, 32'(data), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      nib = prog[4*i-1 -: 4];
      chk($sformatf("%s_bit%0d", tag, i), 32'(bit_out), (i <= n) ? 32'd1 : 32'd0);
      chk($sformatf("%s_valid%0d", tag, i), 32'(bit_valid), 32'd1);
      chk($sformatf("%s_data%0d", tag, i), 32'(data), 32'(nib));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("%s_done%0d", tag, i), 32'(done), (i == 4) ? 32'd1 : 32'd0);
    end
    chk({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    chk({tag, "_loopback"}, 32'($countones(data)), 32'(n));
    tick();
    chk({tag, "_post_done"}, 32'(done), 32'd0);
    chk({tag, "_post_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_post_bit"}, 32'(bit_out), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
    chk({tag, "_post_data"}, 32'(data), 32'(prog[15:12]));
    chk({tag, "_post_sat"}, 32'(sat), 32'(exp_sat));
  endtask

  logic [2:0]  b2b_cnt  [3];
  logic [15:0] b2b_prog [3];
  int          b2b_n    [3];

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    bit_count = 3'd0;
    #1;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(bit_valid), 32'd0);
    chk("rst_bit", 32'(bit_out), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Zero ones: full-length run of zeros, done still pulses.
    run_word("cnt0", 3'd0, 0, 16'h0000, 1'b0);
    // Two ones: 1000, 1100, 0110, 0011.
    run_word("cnt2", 3'd2, 2, 16'h36C8, 1'b0);
    // Exact width, over-range clamp, then sat clears.
    run_word("cnt4", 3'd4, 4, 16'hFEC8, 1'b0);
    run_word("cnt7", 3'd7, 4, 16'hFEC8, 1'b1);
    tick();
    chk("sat_hold_idle", 32'(sat), 32'd1);
    run_word("cnt1", 3'd1, 1, 16'h1248, 1'b0);

    // Back-to-back with start held high: 7, 1, f, one word every 5 cycles.
    b2b_cnt[0] = 3'd3; b2b_n[0] = 3; b2b_prog[0] = 16'h7EC8;
    b2b_cnt[1] = 3'd1; b2b_n[1] = 1; b2b_prog[1] = 16'h1248;
    b2b_cnt[2] = 3'd4; b2b_n[2] = 4; b2b_prog[2] = 16'hFEC8;
    start = 1'b1;
    for (int w = 0; w < 3; w++) begin
      bit_count = b2b_cnt[w];
      tick();
      chk($sformatf("b2b%0d_acc_busy", w), 32'(busy), 32'd1);
      chk($sformatf("b2b%0d_acc_done", w), 32'(done), 32'd0);
      chk($sformatf("b2b%0d_acc_data", w), 32'(data), 32'd0);
      for (int i = 1; i <= 4; i++) begin
        tick();
        chk($sformatf("b2b%0d_bit%0d", w, i), 32'(bit_out), (i <= b2b_n[w]) ? 32'd1 : 32'd0);
        chk($sformatf("b2b%0d_done%0d", w, i), 32'(done), (i == 4) ? 32'd1 : 32'd0);
      end
      chk($sformatf("b2b%0d_data", w), 32'(data), 32'(b2b_prog[w][15:12]));
    end
    start = 1'b0;
    tick();
    chk("b2b_end_done", 32'(done), 32'd0);
    chk("b2b_end_busy", 32'(busy), 32'd0);

    // Start pulsed during SHIFT with a new count is ignored.
    start     = 1'b1;
    bit_count = 3'd2;
    tick();
    start = 1'b0;
    tick();
    start     = 1'b1;
    bit_count = 3'd4;
    tick();
    start = 1'b0;
    chk("ign_data2", 32'(data), 32'hC);
    tick();
    tick();
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_data", 32'(data), 32'h3);
    chk("ign_sat", 32'(sat), 32'd0);
    tick();
    chk("ign_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset after two shifts of a count-3 word.
    start     = 1'b1;
    bit_count = 3'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_data", 32'(data), 32'hC);
    #2;
    reset = 1'b1;
    #1;
    chk("async_data", 32'(data), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_valid", 32'(bit_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("after_rst_busy", 32'(busy), 32'd0);
    run_word("rst1", 3'd1, 1, 16'h1248, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
